// File: rtl/stack_unwind_pkg.sv
// Shared definitions for the stack push/pop machines: word widths, pop FSM states
// and the request-type encoding.
package stack_unwind_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 32;
  localparam int FLAG_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    POP_FLG = 3'd1,
    POP_LO  = 3'd2,
    POP_HI  = 3'd3,
    WAIT    = 3'd4,
    DONE    = 3'd5
  } unwind_state_t;

  typedef enum logic {
    REQ_RET = 1'b0,
    REQ_RTI = 1'b1
  } req_type_t;

  // RTI frames carry a flags word on top, so they start one pop earlier.
  function automatic unwind_state_t first_pop_state(input req_type_t req);
    return (req == REQ_RTI) ? POP_FLG : POP_LO;
  endfunction

endpackage

// File: rtl/stack_unwind_if.sv
// Control and stack-port signals between the pipeline, data memory and the unwind FSM.
import stack_unwind_pkg::*;

interface stack_unwind_if #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int FLAG_W = FLAG_W_DEF
);
  logic                ret_i;
  logic                rti_i;
  logic                push_busy_i;
  logic [ADDR_W-1:0]   sp_i;
  logic                mem_rd_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [DATA_W-1:0]   mem_rdata_i;
  logic                stall_o;
  logic                pc_load_o;
  logic [2*DATA_W-1:0] pc_o;
  logic                flags_load_o;
  logic [FLAG_W-1:0]   flags_o;
  logic                sp_wr_o;
  logic [ADDR_W-1:0]   sp_o;

  // Pipeline/memory side.
  modport master (
    output ret_i, rti_i, push_busy_i, sp_i, mem_rdata_i,
    input  mem_rd_o, mem_addr_o, stall_o, pc_load_o, pc_o,
           flags_load_o, flags_o, sp_wr_o, sp_o
  );

  // Unwind FSM side.
  modport slave (
    input  ret_i, rti_i, push_busy_i, sp_i, mem_rdata_i,
    output mem_rd_o, mem_addr_o, stall_o, pc_load_o, pc_o,
           flags_load_o, flags_o, sp_wr_o, sp_o
  );

endinterface

// File: rtl/stack_unwind_fsm.sv
// RET/RTI stack unwind: pops flags (RTI), PC-lo and PC-hi from the stack,
// then loads PC/flags and writes back SP in one cycle.
import stack_unwind_pkg::*;

module stack_unwind_fsm #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int FLAG_W = FLAG_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  stack_unwind_if.slave bus
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  unwind_state_t       state_reg;
  req_type_t           type_reg;
  logic                pend_valid_reg;
  req_type_t           pend_type_reg;
  logic [ADDR_W-1:0]   ptr_reg;
  logic [DATA_W-1:0]   pc_lo_reg;
  logic [FLAG_W-1:0]   flags_cap_reg;

  logic                mem_rd_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic                stall_reg;
  logic                pc_load_reg;
  logic [2*DATA_W-1:0] pc_reg;
  logic                flags_load_reg;
  logic [FLAG_W-1:0]   flags_reg;
  logic                sp_wr_reg;
  logic [ADDR_W-1:0]   sp_reg;

  logic                pulse;
  logic                req_valid;
  req_type_t           req_type;
  logic                start;

  // A fresh pulse overrides a pending request; RTI wins a simultaneous pulse.
  always_comb begin
    pulse     = bus.ret_i | bus.rti_i;
    req_valid = pulse | pend_valid_reg;
    req_type  = pend_type_reg;
    if (pulse) begin
      req_type = bus.rti_i ? REQ_RTI : REQ_RET;
    end
    start = (state_reg == IDLE) && req_valid && !bus.push_busy_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      type_reg       <= REQ_RET;
      pend_valid_reg <= 1'b0;
      pend_type_reg  <= REQ_RET;
      ptr_reg        <= '0;
      pc_lo_reg      <= '0;
      flags_cap_reg  <= '0;
      mem_rd_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      stall_reg      <= 1'b0;
      pc_load_reg    <= 1'b0;
      pc_reg         <= '0;
      flags_load_reg <= 1'b0;
      flags_reg      <= '0;
      sp_wr_reg      <= 1'b0;
      sp_reg         <= '0;
    end else begin
      pc_load_reg    <= 1'b0;
      flags_load_reg <= 1'b0;
      sp_wr_reg      <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (start) begin
            type_reg       <= req_type;
            pend_valid_reg <= 1'b0;
            ptr_reg        <= bus.sp_i + ADDR_ONE;
            mem_addr_reg   <= bus.sp_i + ADDR_ONE;
            mem_rd_reg     <= 1'b1;
            stall_reg      <= 1'b1;
            state_reg      <= first_pop_state(req_type);
          end else if (pulse) begin
            pend_valid_reg <= 1'b1;
            pend_type_reg  <= req_type;
          end
        end

        POP_FLG: begin
          ptr_reg      <= ptr_reg + ADDR_ONE;
          mem_addr_reg <= ptr_reg + ADDR_ONE;
          mem_rd_reg   <= 1'b1;
          state_reg    <= POP_LO;
        end

        // Read data trails the strobe by one cycle, so each state captures
        // the word requested by the previous one.
        POP_LO: begin
          if (type_reg == REQ_RTI) begin
            flags_cap_reg <= bus.mem_rdata_i[FLAG_W-1:0];
          end
          ptr_reg      <= ptr_reg + ADDR_ONE;
          mem_addr_reg <= ptr_reg + ADDR_ONE;
          mem_rd_reg   <= 1'b1;
          state_reg    <= POP_HI;
        end

        POP_HI: begin
          pc_lo_reg    <= bus.mem_rdata_i;
          ptr_reg      <= ptr_reg + ADDR_ONE;
          mem_addr_reg <= '0;
          mem_rd_reg   <= 1'b0;
          state_reg    <= WAIT;
        end

        // Visible outputs change only here, so an aborted unwind never
        // leaves a half-restored PC, flags or SP.
        WAIT: begin
          pc_reg      <= {bus.mem_rdata_i, pc_lo_reg};
          sp_reg      <= ptr_reg - ADDR_ONE;
          pc_load_reg <= 1'b1;
          sp_wr_reg   <= 1'b1;
          if (type_reg == REQ_RTI) begin
            flags_reg      <= flags_cap_reg;
            flags_load_reg <= 1'b1;
          end
          state_reg <= DONE;
        end

        DONE: begin
          stall_reg <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          mem_rd_reg   <= 1'b0;
          mem_addr_reg <= '0;
          stall_reg    <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_rd_o     = mem_rd_reg;
  assign bus.mem_addr_o   = mem_addr_reg;
  assign bus.stall_o      = stall_reg;
  assign bus.pc_load_o    = pc_load_reg;
  assign bus.pc_o         = pc_reg;
  assign bus.flags_load_o = flags_load_reg;
  assign bus.flags_o      = flags_reg;
  assign bus.sp_wr_o      = sp_wr_reg;
  assign bus.sp_o         = sp_reg;

endmodule

// File: tb/tb_stack_unwind_fsm.sv
// Directed bench for stack_unwind_fsm with a one-cycle-latency stack memory model.
import stack_unwind_pkg::*;

module tb_stack_unwind_fsm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stack_unwind_if bus ();

  stack_unwind_fsm u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem [logic [31:0]];

  always @(posedge clk) begin
    if (bus.mem_rd_o) begin
      bus.mem_rdata_i <= mem.exists(bus.mem_addr_o) ? mem[bus.mem_addr_o] : 16'h0000;
    end
  end

  // Monitor: single writer of all event logs; tasks work on deltas.
  logic [31:0] rd_log [$];
  int stall_cnt = 0, pc_load_cnt = 0, flags_load_cnt = 0, sp_wr_cnt = 0;

  always @(negedge clk) begin
    if (bus.mem_rd_o)      rd_log.push_back(bus.mem_addr_o);
    if (bus.stall_o)       stall_cnt++;
    if (bus.pc_load_o)     pc_load_cnt++;
    if (bus.flags_load_o)  flags_load_cnt++;
    if (bus.sp_wr_o)       sp_wr_cnt++;
  end

  int r0, s0, p0, f0, w0;

  task automatic snap();
    r0 = rd_log.size();
    s0 = stall_cnt;
    p0 = pc_load_cnt;
    f0 = flags_load_cnt;
    w0 = sp_wr_cnt;
  endtask

  task automatic pulse(input logic ret, input logic rti);
    @(negedge clk);
    bus.ret_i = ret;
    bus.rti_i = rti;
    @(negedge clk);
    bus.ret_i = 1'b0;
    bus.rti_i = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({bus.stall_o, bus.mem_rd_o, bus.pc_load_o, bus.flags_load_o, bus.sp_wr_o} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_strobes got=%b want=00000",
               {bus.stall_o, bus.mem_rd_o, bus.pc_load_o, bus.flags_load_o, bus.sp_wr_o});
    end
    vectors++;
    if ({bus.pc_o, bus.flags_o, bus.sp_o, bus.mem_addr_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_values pc=%h flags=%h sp=%h addr=%h want all 0",
               bus.pc_o, bus.flags_o, bus.sp_o, bus.mem_addr_o);
    end
    $display("test_reset: outputs checked under reset");
  endtask

  task automatic test_ret();
    mem[32'h0000_0FF1] = 16'h1234;
    mem[32'h0000_0FF2] = 16'hABCD;
    bus.sp_i = 32'h0000_0FF0;
    snap();
    pulse(1'b1, 1'b0);
    repeat (8) @(negedge clk);
    vectors++;
    if (rd_log.size() - r0 != 2 || rd_log[r0] !== 32'h0FF1 || rd_log[r0+1] !== 32'h0FF2) begin
      miscompares++;
      $display("FAIL ret_reads n=%0d a0=%h a1=%h want n=2 a0=00000ff1 a1=00000ff2",
               rd_log.size() - r0, rd_log[r0], rd_log[r0+1]);
    end
    vectors++;
    if (stall_cnt - s0 != 4) begin
      miscompares++;
      $display("FAIL ret_stall got=%0d want=4", stall_cnt - s0);
    end
    vectors++;
    if (bus.pc_o !== 32'hABCD_1234 || bus.sp_o !== 32'h0000_0FF2) begin
      miscompares++;
      $display("FAIL ret_pc_sp pc=%h sp=%h want pc=abcd1234 sp=00000ff2", bus.pc_o, bus.sp_o);
    end
    vectors++;
    if (pc_load_cnt - p0 != 1 || sp_wr_cnt - w0 != 1 || flags_load_cnt - f0 != 0) begin
      miscompares++;
      $display("FAIL ret_strobes pc_load=%0d sp_wr=%0d flags_load=%0d want 1 1 0",
               pc_load_cnt - p0, sp_wr_cnt - w0, flags_load_cnt - f0);
    end
    $display("test_ret: sp=%h pc=%h sp_o=%h", 32'h0FF0, bus.pc_o, bus.sp_o);
  endtask

  task automatic test_rti(input logic both);
    logic [31:0] base;
    base = both ? 32'h0000_0400 : 32'h0000_0100;
    mem[base + 1] = both ? 16'h0005 : 16'h000B;
    mem[base + 2] = both ? 16'h9ABC : 16'h5678;
    mem[base + 3] = both ? 16'hDEF0 : 16'h0001;
    bus.sp_i = base;
    snap();
    pulse(both, 1'b1);
    repeat (9) @(negedge clk);
    vectors++;
    if (rd_log.size() - r0 != 3 || rd_log[r0] !== base + 1 || rd_log[r0+1] !== base + 2
        || rd_log[r0+2] !== base + 3) begin
      miscompares++;
      $display("FAIL rti_reads both=%0b n=%0d a0=%h a1=%h a2=%h want n=3 from %h",
               both, rd_log.size() - r0, rd_log[r0], rd_log[r0+1], rd_log[r0+2], base + 1);
    end
    vectors++;
    if (stall_cnt - s0 != 5) begin
      miscompares++;
      $display("FAIL rti_stall both=%0b got=%0d want=5", both, stall_cnt - s0);
    end
    vectors++;
    if (bus.flags_o !== (both ? 4'h5 : 4'hB) || bus.pc_o !== (both ? 32'hDEF0_9ABC : 32'h0001_5678)
        || bus.sp_o !== base + 3) begin
      miscompares++;
      $display("FAIL rti_values both=%0b flags=%h pc=%h sp=%h want flags=%h pc=%h sp=%h",
               both, bus.flags_o, bus.pc_o, bus.sp_o, (both ? 4'h5 : 4'hB),
               (both ? 32'hDEF0_9ABC : 32'h0001_5678), base + 3);
    end
    vectors++;
    if (pc_load_cnt - p0 != 1 || sp_wr_cnt - w0 != 1 || flags_load_cnt - f0 != 1) begin
      miscompares++;
      $display("FAIL rti_strobes both=%0b pc_load=%0d sp_wr=%0d flags_load=%0d want 1 1 1",
               both, pc_load_cnt - p0, sp_wr_cnt - w0, flags_load_cnt - f0);
    end
    $display("test_rti(both=%0b): pc=%h flags=%h sp_o=%h", both, bus.pc_o, bus.flags_o, bus.sp_o);
  endtask

  task automatic test_push_busy();
    mem[32'h0000_0301] = 16'hBEEF;
    mem[32'h0000_0302] = 16'hCAFE;
    bus.sp_i = 32'h0000_0300;
    snap();
    @(negedge clk);
    bus.push_busy_i = 1'b1;
    pulse(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    vectors++;
    if (rd_log.size() != r0 || stall_cnt != s0) begin
      miscompares++;
      $display("FAIL busy_hold reads=%0d stall=%0d want 0 0", rd_log.size() - r0, stall_cnt - s0);
    end
    bus.push_busy_i = 1'b0;
    repeat (8) @(negedge clk);
    vectors++;
    if (rd_log.size() - r0 != 2 || rd_log[r0] !== 32'h0301 || rd_log[r0+1] !== 32'h0302
        || stall_cnt - s0 != 4) begin
      miscompares++;
      $display("FAIL busy_release n=%0d a0=%h a1=%h stall=%0d want n=2 301 302 stall=4",
               rd_log.size() - r0, rd_log[r0], rd_log[r0+1], stall_cnt - s0);
    end
    vectors++;
    if (bus.pc_o !== 32'hCAFE_BEEF || bus.sp_o !== 32'h0000_0302) begin
      miscompares++;
      $display("FAIL busy_pc_sp pc=%h sp=%h want cafebeef 00000302", bus.pc_o, bus.sp_o);
    end
    $display("test_push_busy: pc=%h sp_o=%h", bus.pc_o, bus.sp_o);
  endtask

  task automatic test_reset_mid();
    mem[32'h0000_0501] = 16'h5555;
    mem[32'h0000_0502] = 16'h6666;
    bus.sp_i = 32'h0000_0500;
    snap();
    pulse(1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.stall_o, bus.mem_rd_o, bus.pc_load_o, bus.sp_wr_o} !== 4'b0
        || {bus.pc_o, bus.flags_o, bus.sp_o, bus.mem_addr_o} !== '0) begin
      miscompares++;
      $display("FAIL midrst_outputs stall=%b rd=%b pc=%h flags=%h sp=%h addr=%h want all 0",
               bus.stall_o, bus.mem_rd_o, bus.pc_o, bus.flags_o, bus.sp_o, bus.mem_addr_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    vectors++;
    if (pc_load_cnt != p0 || sp_wr_cnt != w0 || flags_load_cnt != f0) begin
      miscompares++;
      $display("FAIL midrst_no_load pc_load=%0d sp_wr=%0d flags_load=%0d want 0 0 0",
               pc_load_cnt - p0, sp_wr_cnt - w0, flags_load_cnt - f0);
    end
    mem[32'h0000_0201] = 16'h1111;
    mem[32'h0000_0202] = 16'h2222;
    bus.sp_i = 32'h0000_0200;
    snap();
    pulse(1'b1, 1'b0);
    repeat (8) @(negedge clk);
    vectors++;
    if (bus.pc_o !== 32'h2222_1111 || bus.sp_o !== 32'h0000_0202 || stall_cnt - s0 != 4
        || pc_load_cnt - p0 != 1) begin
      miscompares++;
      $display("FAIL midrst_recover pc=%h sp=%h stall=%0d pc_load=%0d want 22221111 00000202 4 1",
               bus.pc_o, bus.sp_o, stall_cnt - s0, pc_load_cnt - p0);
    end
    $display("test_reset_mid: recovered pc=%h sp_o=%h", bus.pc_o, bus.sp_o);
  endtask

  task automatic test_wrap();
    mem[32'h0000_0000] = 16'h0F0F;
    mem[32'h0000_0001] = 16'h7777;
    bus.sp_i = 32'hFFFF_FFFF;
    snap();
    pulse(1'b1, 1'b0);
    repeat (8) @(negedge clk);
    vectors++;
    if (rd_log.size() - r0 != 2 || rd_log[r0] !== 32'h0 || rd_log[r0+1] !== 32'h1) begin
      miscompares++;
      $display("FAIL wrap_reads n=%0d a0=%h a1=%h want n=2 0 1",
               rd_log.size() - r0, rd_log[r0], rd_log[r0+1]);
    end
    vectors++;
    if (bus.pc_o !== 32'h7777_0F0F || bus.sp_o !== 32'h0000_0001) begin
      miscompares++;
      $display("FAIL wrap_pc_sp pc=%h sp=%h want 77770f0f 00000001", bus.pc_o, bus.sp_o);
    end
    $display("test_wrap: pc=%h sp_o=%h", bus.pc_o, bus.sp_o);
  endtask

  initial begin
    rst = 1'b1;
    bus.ret_i = 1'b0;
    bus.rti_i = 1'b0;
    bus.push_busy_i = 1'b0;
    bus.sp_i = '0;
    repeat (2) @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_ret();
    test_rti(1'b0);
    test_push_busy();
    test_rti(1'b1);
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
